// File: rtl/alu_regfile_flags.sv
// alu_regfile_flags: general register file plus {N,Z,C,V} status-flag register.
// Two asynchronous read ports supply ALU operands, one synchronous write port
// absorbs the ALU result, and a 3-bit branch condition is decoded from the flags.
// Optional feature macro: ALU_REGFILE_FWD_EN enables write-through bypass on the
// read ports, and evaluates take on the incoming flags while flag_we is high.
module alu_regfile_flags #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 4,
  parameter int unsigned ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flag_we,
  input  logic              carry_in,
  input  logic              ovf_in,
  input  logic              neg_in,
  input  logic              zero_in,
  output logic [3:0]        flags,
  input  logic [2:0]        cond,
  output logic              take
);

  logic [DATA_W-1:0] regs [NREG];
  logic [3:0]        flags_q;
  logic [3:0]        flags_eval;

  // Register file: async clear of every entry, single write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Flag register, packed {N,Z,C,V}
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags_q <= '0;
    end else if (flag_we) begin
      flags_q <= {neg_in, zero_in, carry_in, ovf_in};
    end
  end

  assign flags = flags_q;

`ifdef ALU_REGFILE_FWD_EN
  // Read ports with write-through bypass on an address match
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
    if (wr_en && (wr_addr == ra_addr)) ra_data = wr_data;
    if (wr_en && (wr_addr == rb_addr)) rb_data = wr_data;
  end

  // Condition source: incoming flags while they are being latched
  always_comb begin
    flags_eval = flags_q;
    if (flag_we) flags_eval = {neg_in, zero_in, carry_in, ovf_in};
  end
`else
  // Read ports: registered state only, same-cycle writes not visible
  always_comb begin
    ra_data = regs[ra_addr];
    rb_data = regs[rb_addr];
  end

  // Condition source: registered flags only
  always_comb begin
    flags_eval = flags_q;
  end
`endif

  // Branch condition decode against {N,Z,C,V}
  always_comb begin
    take = 1'b0;
    case (cond)
      3'b000:  take = 1'b1;
      3'b001:  take = flags_eval[2];
      3'b010:  take = ~flags_eval[2];
      3'b011:  take = flags_eval[1];
      3'b100:  take = ~flags_eval[1];
      3'b101:  take = flags_eval[3];
      3'b110:  take = flags_eval[0];
      default: take = 1'b0;
    endcase
  end

endmodule
